surface_hit_reducer: RTL and testbench
======================================

# surface_hit_reducer

Parametrised closest-hit accumulator for the SURF stage. It tracks up to CTX surface rays in flight and folds LANES candidate hits per cycle into a per-ray best hit, keyed on the smallest T. It returns each finished ray's closest hit through a registered valid/ready output with round-robin fairness. It sits between the ray-unit hit tests and the surface output stage and replaces the single-ray closest-hit register with a multi-context, multi-lane, back-pressured block.

## Interface
- CTX, default 4: ray contexts in flight; ID_W = clog2(CTX), minimum 1.
- LANES, default 2: candidate hits accepted per cycle.
- T_W, default 32: signed fixed-point T width; T_MAX = 0 followed by T_W-1 ones.
- PAY_W, default 64: opaque hit payload (primitive index, normal, color, surface type).

- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- open_valid  in  1  request a new ray context.
- open_payload  in  PAY_W  initial payload (clear color, no hit).
- open_ready  out  1  a FREE context exists (combinational).
- open_id  out  ID_W  lowest-index FREE context (combinational); valid when open_ready.
- cand_valid  in  LANES  per-lane candidate strobe.
- cand_hit  in  LANES  lane reports an actual intersection.
- cand_ctx  in  LANES*ID_W  target context per lane.
- cand_t  in  LANES*T_W  signed hit distance per lane.
- cand_payload  in  LANES*PAY_W  hit payload per lane.
- close_valid  in  1  traversal of close_ctx is finished.
- close_ctx  in  ID_W  context being closed.
- out_valid  out  1  result held in the output register.
- out_ready  in  1  consumer accepts.
- out_ctx  out  ID_W  context of the result.
- out_hit  out  1  at least one candidate was accepted.
- out_t  out  T_W  best T (T_MAX if no hit).
- out_payload  out  PAY_W  best payload (open_payload if no hit).
- drop_count  out  16  saturating count of candidates aimed at non-ACTIVE contexts.

## Operation
- Context states: FREE -> ACTIVE (open handshake) -> DONE (close) -> OUT (loaded into output register) -> FREE (out handshake).
- Open: on open_valid && open_ready, context open_id becomes ACTIVE with best_t = T_MAX, hit = 0, payload = open_payload.
- Candidate acceptance: the lane is valid, the lane is a hit, the target context is ACTIVE, and cand_t < current best (strict signed compare).
- Several lanes may target the same context in one cycle. They are reduced in lane order with strict less-than, so on equal T the lower lane wins and a stored value beats a new equal one.
- An accepted candidate sets hit = 1 and replaces best_t and payload.
- Dropped candidates: valid lanes aimed at FREE, DONE or OUT contexts are ignored and each increments drop_count. drop_count holds at 0xFFFF. Valid non-hit lanes on ACTIVE contexts are ignored without counting.
- Close: close_valid on an ACTIVE context moves it to DONE after that cycle's candidates are applied. Close on a non-ACTIVE context is ignored.
- Output selection: when the output register is empty, or is handshaking this cycle, it loads the first DONE context found searching from rr_ptr upward with wrap-around. The loaded context becomes OUT and rr_ptr moves to the loaded index + 1, mod CTX.
- Free on handshake: out_valid && out_ready frees the OUT context at the clock edge. It is not offered on open_id until the next cycle.
- Output hold: out_* stay stable while out_valid && !out_ready.
- Simultaneous open and candidates: a candidate for the context being opened in the same cycle is dropped, because that context is still FREE.

## Timing
- Reset (asynchronous): all contexts FREE, best_t = T_MAX, hit = 0, payload = 0; out_valid = 0, out_ctx = 0, out_hit = 0, out_t = T_MAX, out_payload = 0; drop_count = 0, rr_ptr = 0. Reset mid-operation discards every context and any pending output.
- Candidate at cycle n: visible in the context state at n+1.
- Close at cycle n: DONE at n+1; out_valid at n+2 if the output register is free.
- Back-to-back results: one per cycle when out_ready is held high.
- Full condition: open_ready = 0 when all CTX contexts are ACTIVE, DONE or OUT.

## Test plan
- Single ray, one hit: open (id 0), lane0 t = 0x00050000 hit, close at cycle 3 -> out_valid at cycle 5 with ctx 0, hit 1, t 0x00050000 and the lane payload; the next open returns id 0.
- Same-cycle reduction: ctx 1 receives lane0 t = 7, lane1 t = 3, then next cycle lane0 t = 3 -> result t = 3 with lane1's first payload (the stored value wins the tie).
- No-hit ray: open with payload 0xAA, only cand_hit = 0 candidates, then close -> out_hit 0, t T_MAX, payload 0xAA, drop_count unchanged.
- Full and back-pressure: open 4 contexts -> open_ready = 0; close all 4 with out_ready = 0 -> out_ctx 0 held stable for 10 cycles; raise out_ready -> results for ctx 0, 1, 2, 3 on consecutive cycles, and open_ready returns 1 the cycle after the first handshake.
- Drops and ordering: a candidate for a FREE ctx, a candidate in the same cycle as its own open, and a candidate in the cycle after close -> drop_count = 3. Close combined with a same-cycle candidate t = 2 -> that candidate is included in the result.
- Asynchronous reset asserted mid-stream, with 3 ACTIVE contexts and out_valid = 1 -> all outputs take their reset values immediately, without waiting for a clock edge; open_id = 0 and open_ready = 1 after release.

Source files
------------

// File: rtl/surface_hit_reducer.sv
// rtl/surface_hit_reducer.sv - multi-context, multi-lane closest-hit accumulator
//
// Tracks up to CTX surface rays in flight. LANES candidate hits per cycle are
// folded into a per-ray best hit, keyed on the smallest signed T. Finished rays
// are returned one at a time through a registered valid/ready output. The
// output picks among finished rays in round-robin order.
//
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   open_*             allocate a context: valid/payload in, ready/id out
//   cand_*             per-lane candidate hits (valid, hit, ctx, t, payload)
//   close_*            mark a context's traversal finished
//   out_*              registered result (valid/ready, ctx, hit, t, payload)
//   drop_count         saturating count of candidates aimed at non-ACTIVE contexts
module surface_hit_reducer #(
  parameter int CTX   = 4,
  parameter int LANES = 2,
  parameter int T_W   = 32,
  parameter int PAY_W = 64,
  parameter int ID_W  = (CTX > 1) ? $clog2(CTX) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   open_valid,
  input  logic [PAY_W-1:0]       open_payload,
  output logic                   open_ready,
  output logic [ID_W-1:0]        open_id,
  input  logic [LANES-1:0]       cand_valid,
  input  logic [LANES-1:0]       cand_hit,
  input  logic [LANES*ID_W-1:0]  cand_ctx,
  input  logic [LANES*T_W-1:0]   cand_t,
  input  logic [LANES*PAY_W-1:0] cand_payload,
  input  logic                   close_valid,
  input  logic [ID_W-1:0]        close_ctx,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ID_W-1:0]        out_ctx,
  output logic                   out_hit,
  output logic [T_W-1:0]         out_t,
  output logic [PAY_W-1:0]       out_payload,
  output logic [15:0]            drop_count
);

  localparam logic [1:0] ST_FREE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;
  localparam logic [1:0] ST_OUT    = 2'd3;

  localparam int IW1 = ID_W + 1;
  localparam logic [T_W-1:0] T_MAX = {1'b0, {(T_W-1){1'b1}}};

  // Per-context storage
  logic [1:0]       ctx_st  [CTX];
  logic [T_W-1:0]   ctx_t   [CTX];
  logic             ctx_hit [CTX];
  logic [PAY_W-1:0] ctx_pay [CTX];

  // Reduced (post-candidate) values for each context
  logic [T_W-1:0]   red_t   [CTX];
  logic             red_hit [CTX];
  logic [PAY_W-1:0] red_pay [CTX];

  logic [LANES-1:0] lane_active;
  logic [16:0]      drop_sum;
  logic [15:0]      drop_next;

  logic [CTX-1:0]   done_vec;
  logic [IW1-1:0]   idx_w;
  logic             sel_found;
  logic [ID_W-1:0]  sel_idx;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  rr_next;
  logic             load_en;
  logic             out_fire;

  // Lowest-index FREE context; scanning downward leaves the lowest one last.
  always_comb begin
    open_ready = 1'b0;
    open_id    = '0;
    for (int c = CTX - 1; c >= 0; c--) begin
      if (ctx_st[c] == ST_FREE) begin
        open_ready = 1'b1;
        open_id    = ID_W'(c);
      end
    end
  end

  // Lane-order reduction per context. The running best includes lanes already
  // folded this cycle, so strict less-than keeps the lower lane (or the stored
  // value) on ties.
  always_comb begin
    for (int c = 0; c < CTX; c++) begin
      red_t[c]   = ctx_t[c];
      red_hit[c] = ctx_hit[c];
      red_pay[c] = ctx_pay[c];
      if (ctx_st[c] == ST_ACTIVE) begin
        for (int l = 0; l < LANES; l++) begin
          if (cand_valid[l] && cand_hit[l] &&
              (cand_ctx[l*ID_W +: ID_W] == ID_W'(c)) &&
              ($signed(cand_t[l*T_W +: T_W]) < $signed(red_t[c]))) begin
            red_t[c]   = cand_t[l*T_W +: T_W];
            red_hit[c] = 1'b1;
            red_pay[c] = cand_payload[l*PAY_W +: PAY_W];
          end
        end
      end
    end
  end

  // Any valid lane whose target is not ACTIVE is a drop, hit or not. A target
  // index beyond CTX-1 never matches and so also counts as a drop.
  always_comb begin
    lane_active = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int c = 0; c < CTX; c++) begin
        if ((cand_ctx[l*ID_W +: ID_W] == ID_W'(c)) && (ctx_st[c] == ST_ACTIVE))
          lane_active[l] = 1'b1;
      end
    end
  end

  always_comb begin
    drop_sum = {1'b0, drop_count};
    for (int l = 0; l < LANES; l++) begin
      if (cand_valid[l] && !lane_active[l])
        drop_sum = drop_sum + 17'd1;
    end
    drop_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  // Round-robin search for a DONE context starting at rr_ptr
  always_comb begin
    for (int c = 0; c < CTX; c++)
      done_vec[c] = (ctx_st[c] == ST_DONE);
  end

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    idx_w     = '0;
    for (int k = 0; k < CTX; k++) begin
      idx_w = {1'b0, rr_ptr} + IW1'(k);
      if (idx_w >= IW1'(CTX))
        idx_w = idx_w - IW1'(CTX);
      if (!sel_found && done_vec[idx_w[ID_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = idx_w[ID_W-1:0];
      end
    end
  end

  assign out_fire = out_valid && out_ready;
  assign load_en  = (!out_valid || out_ready) && sel_found;
  assign rr_next  = (sel_idx == ID_W'(CTX - 1)) ? '0 : sel_idx + 1'b1;

  // Each state has exactly one way out, so open, reduce/close, load and free
  // never compete for the same context.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < CTX; c++) begin
        ctx_st[c]  <= ST_FREE;
        ctx_t[c]   <= T_MAX;
        ctx_hit[c] <= 1'b0;
        ctx_pay[c] <= '0;
      end
    end else begin
      for (int c = 0; c < CTX; c++) begin
        case (ctx_st[c])
          ST_FREE: begin
            if (open_valid && open_ready && (open_id == ID_W'(c))) begin
              ctx_st[c]  <= ST_ACTIVE;
              ctx_t[c]   <= T_MAX;
              ctx_hit[c] <= 1'b0;
              ctx_pay[c] <= open_payload;
            end
          end
          ST_ACTIVE: begin
            ctx_t[c]   <= red_t[c];
            ctx_hit[c] <= red_hit[c];
            ctx_pay[c] <= red_pay[c];
            // Candidates of the closing cycle are still folded in above.
            if (close_valid && (close_ctx == ID_W'(c)))
              ctx_st[c] <= ST_DONE;
          end
          ST_DONE: begin
            if (load_en && (sel_idx == ID_W'(c)))
              ctx_st[c] <= ST_OUT;
          end
          default: begin
            if (out_fire && (out_ctx == ID_W'(c)))
              ctx_st[c] <= ST_FREE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_ctx     <= '0;
      out_hit     <= 1'b0;
      out_t       <= T_MAX;
      out_payload <= '0;
      rr_ptr      <= '0;
    end else if (load_en) begin
      out_valid   <= 1'b1;
      out_ctx     <= sel_idx;
      out_hit     <= ctx_hit[sel_idx];
      out_t       <= ctx_t[sel_idx];
      out_payload <= ctx_pay[sel_idx];
      rr_ptr      <= rr_next;
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      drop_count <= 16'd0;
    else
      drop_count <= drop_next;
  end

endmodule

// File: tb/tb_surface_hit_reducer.sv
// tb/tb_surface_hit_reducer.sv - directed self-checking bench for surface_hit_reducer
module tb_surface_hit_reducer;
  localparam int CTX   = 4;
  localparam int LANES = 2;
  localparam int T_W   = 32;
  localparam int PAY_W = 64;
  localparam int ID_W  = 2;
  localparam logic [T_W-1:0] T_MAX = 32'h7FFF_FFFF;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   open_valid;
  logic [PAY_W-1:0]       open_payload;
  logic                   open_ready;
  logic [ID_W-1:0]        open_id;
  logic [LANES-1:0]       cand_valid;
  logic [LANES-1:0]       cand_hit;
  logic [LANES*ID_W-1:0]  cand_ctx;
  logic [LANES*T_W-1:0]   cand_t;
  logic [LANES*PAY_W-1:0] cand_payload;
  logic                   close_valid;
  logic [ID_W-1:0]        close_ctx;
  logic                   out_valid;
  logic                   out_ready;
  logic [ID_W-1:0]        out_ctx;
  logic                   out_hit;
  logic [T_W-1:0]         out_t;
  logic [PAY_W-1:0]       out_payload;
  logic [15:0]            drop_count;

  int n_checks = 0;
  int n_fail   = 0;

  surface_hit_reducer #(.CTX(CTX), .LANES(LANES), .T_W(T_W), .PAY_W(PAY_W)) dut (
    .clk(clk), .reset(reset),
    .open_valid(open_valid), .open_payload(open_payload),
    .open_ready(open_ready), .open_id(open_id),
    .cand_valid(cand_valid), .cand_hit(cand_hit), .cand_ctx(cand_ctx),
    .cand_t(cand_t), .cand_payload(cand_payload),
    .close_valid(close_valid), .close_ctx(close_ctx),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctx(out_ctx),
    .out_hit(out_hit), .out_t(out_t), .out_payload(out_payload),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    open_valid   = 1'b0;
    open_payload = '0;
    cand_valid   = '0;
    cand_hit     = '0;
    cand_ctx     = '0;
    cand_t       = '0;
    cand_payload = '0;
    close_valid  = 1'b0;
    close_ctx    = '0;
  endtask

  task automatic set_lane(input int l, input logic h, input logic [ID_W-1:0] c,
                          input logic [T_W-1:0] t, input logic [PAY_W-1:0] p);
    cand_valid[l]               = 1'b1;
    cand_hit[l]                 = h;
    cand_ctx[l*ID_W +: ID_W]    = c;
    cand_t[l*T_W +: T_W]        = t;
    cand_payload[l*PAY_W +: PAY_W] = p;
  endtask

  task automatic do_reset;
    clear_inputs();
    out_ready = 1'b0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic open_one(input logic [PAY_W-1:0] p);
    open_valid   = 1'b1;
    open_payload = p;
    step();
    clear_inputs();
  endtask

  task automatic close_one(input logic [ID_W-1:0] c);
    close_valid = 1'b1;
    close_ctx   = c;
    step();
    clear_inputs();
  endtask

  task automatic test_reset;
    do_reset();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got=%h want=0", out_valid); end
    n_checks++; if (out_ctx !== 2'd0) begin n_fail++; $display("FAIL rst_out_ctx got=%h want=0", out_ctx); end
    n_checks++; if (out_hit !== 1'b0) begin n_fail++; $display("FAIL rst_out_hit got=%h want=0", out_hit); end
    n_checks++; if (out_t !== T_MAX) begin n_fail++; $display("FAIL rst_out_t got=%h want=%h", out_t, T_MAX); end
    n_checks++; if (out_payload !== 64'd0) begin n_fail++; $display("FAIL rst_out_payload got=%h want=0", out_payload); end
    n_checks++; if (drop_count !== 16'd0) begin n_fail++; $display("FAIL rst_drop got=%h want=0", drop_count); end
    n_checks++; if (open_ready !== 1'b1) begin n_fail++; $display("FAIL rst_open_ready got=%h want=1", open_ready); end
    n_checks++; if (open_id !== 2'd0) begin n_fail++; $display("FAIL rst_open_id got=%h want=0", open_id); end
  endtask

  task automatic test_single_hit;
    do_reset();
    open_one(64'h1111);
    set_lane(0, 1'b1, 2'd0, 32'h0005_0000, 64'hCAFE);
    step();
    clear_inputs();
    close_one(2'd0);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid got=%h want=0", out_valid); end
    step();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got=%h want=1", out_valid); end
    n_checks++; if (out_ctx !== 2'd0) begin n_fail++; $display("FAIL single_ctx got=%h want=0", out_ctx); end
    n_checks++; if (out_hit !== 1'b1) begin n_fail++; $display("FAIL single_hit got=%h want=1", out_hit); end
    n_checks++; if (out_t !== 32'h0005_0000) begin n_fail++; $display("FAIL single_t got=%h want=00050000", out_t); end
    n_checks++; if (out_payload !== 64'hCAFE) begin n_fail++; $display("FAIL single_payload got=%h want=cafe", out_payload); end
    n_checks++; if (open_id !== 2'd1) begin n_fail++; $display("FAIL single_open_id_busy got=%h want=1", open_id); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drained got=%h want=0", out_valid); end
    n_checks++; if (open_id !== 2'd0) begin n_fail++; $display("FAIL single_reopen_id got=%h want=0", open_id); end
  endtask

  task automatic test_reduction;
    do_reset();
    open_one(64'h10);
    open_one(64'h20);
    set_lane(0, 1'b1, 2'd1, 32'd7, 64'h70);
    set_lane(1, 1'b1, 2'd1, 32'd3, 64'h31);
    step();
    clear_inputs();
    set_lane(0, 1'b1, 2'd1, 32'd3, 64'h32);
    set_lane(1, 1'b1, 2'd0, 32'hFFFF_FFF0, 64'h99);
    step();
    clear_inputs();
    close_one(2'd1);
    close_one(2'd0);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL red_valid got=%h want=1", out_valid); end
    n_checks++; if (out_ctx !== 2'd1) begin n_fail++; $display("FAIL red_ctx got=%h want=1", out_ctx); end
    n_checks++; if (out_t !== 32'd3) begin n_fail++; $display("FAIL red_t got=%h want=3", out_t); end
    n_checks++; if (out_payload !== 64'h31) begin n_fail++; $display("FAIL red_payload got=%h want=31", out_payload); end
    out_ready = 1'b1;
    step();
    n_checks++; if (out_ctx !== 2'd0) begin n_fail++; $display("FAIL neg_ctx got=%h want=0", out_ctx); end
    n_checks++; if (out_t !== 32'hFFFF_FFF0) begin n_fail++; $display("FAIL neg_t got=%h want=fffffff0", out_t); end
    n_checks++; if (out_payload !== 64'h99) begin n_fail++; $display("FAIL neg_payload got=%h want=99", out_payload); end
    step();
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL red_drained got=%h want=0", out_valid); end
    n_checks++; if (drop_count !== 16'd0) begin n_fail++; $display("FAIL red_drop got=%h want=0", drop_count); end
  endtask

  task automatic test_no_hit;
    do_reset();
    open_one(64'hAA);
    set_lane(0, 1'b0, 2'd0, 32'd1, 64'h1);
    set_lane(1, 1'b0, 2'd0, 32'd0, 64'h2);
    step();
    clear_inputs();
    close_one(2'd0);
    step();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL nohit_valid got=%h want=1", out_valid); end
    n_checks++; if (out_hit !== 1'b0) begin n_fail++; $display("FAIL nohit_hit got=%h want=0", out_hit); end
    n_checks++; if (out_t !== T_MAX) begin n_fail++; $display("FAIL nohit_t got=%h want=%h", out_t, T_MAX); end
    n_checks++; if (out_payload !== 64'hAA) begin n_fail++; $display("FAIL nohit_payload got=%h want=aa", out_payload); end
    n_checks++; if (drop_count !== 16'd0) begin n_fail++; $display("FAIL nohit_drop got=%h want=0", drop_count); end
  endtask

  task automatic test_back_to_back;
    do_reset();
    for (int i = 0; i < CTX; i++) begin
      n_checks++; if (open_id !== 2'(i)) begin n_fail++; $display("FAIL full_open_id%0d got=%h want=%0d", i, open_id, i); end
      open_one(64'(32'h100 + i));
    end
    n_checks++; if (open_ready !== 1'b0) begin n_fail++; $display("FAIL full_open_ready got=%h want=0", open_ready); end
    for (int i = 0; i < CTX; i++) close_one(2'(i));
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++; if (out_valid !== 1'b1 || out_ctx !== 2'd0 || out_payload !== 64'h100) begin
        n_fail++; $display("FAIL hold%0d got valid=%h ctx=%h pay=%h want 1/0/100", i, out_valid, out_ctx, out_payload);
      end
    end
    n_checks++; if (open_ready !== 1'b0) begin n_fail++; $display("FAIL hold_open_ready got=%h want=0", open_ready); end
    out_ready = 1'b1;
    step();
    n_checks++; if (out_ctx !== 2'd1 || out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_ctx1 got ctx=%h valid=%h", out_ctx, out_valid); end
    n_checks++; if (open_ready !== 1'b1 || open_id !== 2'd0) begin n_fail++; $display("FAIL b2b_reopen got ready=%h id=%h want 1/0", open_ready, open_id); end
    step();
    n_checks++; if (out_ctx !== 2'd2 || out_payload !== 64'h102) begin n_fail++; $display("FAIL b2b_ctx2 got ctx=%h pay=%h", out_ctx, out_payload); end
    step();
    n_checks++; if (out_ctx !== 2'd3 || out_payload !== 64'h103) begin n_fail++; $display("FAIL b2b_ctx3 got ctx=%h pay=%h", out_ctx, out_payload); end
    step();
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drained got=%h want=0", out_valid); end
  endtask

  task automatic test_drops;
    do_reset();
    open_valid   = 1'b1;
    open_payload = 64'h55;
    set_lane(0, 1'b1, 2'd2, 32'd5, 64'h5);
    set_lane(1, 1'b1, 2'd0, 32'd4, 64'h4);
    step();
    clear_inputs();
    n_checks++; if (drop_count !== 16'd2) begin n_fail++; $display("FAIL drop_two got=%h want=2", drop_count); end
    close_valid = 1'b1;
    close_ctx   = 2'd0;
    set_lane(0, 1'b1, 2'd0, 32'd2, 64'h22);
    set_lane(1, 1'b1, 2'd0, 32'd2, 64'h23);
    step();
    clear_inputs();
    set_lane(0, 1'b1, 2'd0, 32'd1, 64'h11);
    step();
    clear_inputs();
    n_checks++; if (drop_count !== 16'd3) begin n_fail++; $display("FAIL drop_three got=%h want=3", drop_count); end
    n_checks++; if (out_valid !== 1'b1 || out_hit !== 1'b1) begin n_fail++; $display("FAIL close_cand_valid got valid=%h hit=%h", out_valid, out_hit); end
    n_checks++; if (out_t !== 32'd2) begin n_fail++; $display("FAIL close_cand_t got=%h want=2", out_t); end
    n_checks++; if (out_payload !== 64'h22) begin n_fail++; $display("FAIL close_cand_payload got=%h want=22", out_payload); end
  endtask

  task automatic test_drop_saturate;
    do_reset();
    set_lane(0, 1'b1, 2'd1, 32'd1, 64'h0);
    set_lane(1, 1'b0, 2'd2, 32'd1, 64'h0);
    for (int i = 0; i < 32767; i++) step();
    n_checks++; if (drop_count !== 16'hFFFE) begin n_fail++; $display("FAIL sat_fffe got=%h want=fffe", drop_count); end
    cand_valid = 2'b01;
    step();
    n_checks++; if (drop_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_ffff got=%h want=ffff", drop_count); end
    cand_valid = 2'b11;
    step();
    clear_inputs();
    n_checks++; if (drop_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold got=%h want=ffff", drop_count); end
  endtask

  task automatic test_async_reset;
    do_reset();
    for (int i = 0; i < CTX; i++) open_one(64'(32'h200 + i));
    set_lane(0, 1'b1, 2'd3, 32'd9, 64'h9);
    step();
    clear_inputs();
    close_one(2'd3);
    step();
    set_lane(0, 1'b1, 2'd3, 32'd9, 64'h9);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ar_pre_valid got=%h want=1", out_valid); end
    #2;
    reset = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0 || out_ctx !== 2'd0 || out_hit !== 1'b0) begin
      n_fail++; $display("FAIL ar_out got valid=%h ctx=%h hit=%h want 0/0/0", out_valid, out_ctx, out_hit);
    end
    n_checks++; if (out_t !== T_MAX || out_payload !== 64'd0) begin n_fail++; $display("FAIL ar_data got t=%h pay=%h", out_t, out_payload); end
    n_checks++; if (drop_count !== 16'd0) begin n_fail++; $display("FAIL ar_drop got=%h want=0", drop_count); end
    n_checks++; if (open_ready !== 1'b1 || open_id !== 2'd0) begin n_fail++; $display("FAIL ar_open got ready=%h id=%h", open_ready, open_id); end
    clear_inputs();
    step();
    reset = 1'b0;
    step();
    n_checks++; if (open_ready !== 1'b1 || open_id !== 2'd0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL ar_release got ready=%h id=%h valid=%h", open_ready, open_id, out_valid);
    end
  endtask

  initial begin
    clear_inputs();
    out_ready = 1'b0;
    test_reset();
    test_single_hit();
    test_reduction();
    test_no_hit();
    test_back_to_back();
    test_drops();
    test_drop_saturate();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
